pipeline_stall_controller: RTL and testbench
============================================

// Module: pipeline_stall_controller
// PURPOSE
//  Central stall/flush scheduler for the 5-stage 16-bit pipeline.
//  Arbitrates between data-memory wait, taken-branch flush and load-use bubble requests.
//  Drives one coherent set of write-enable, flush and bubble controls to PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
//  Also owns the halt and memory-timeout states and a stall-cycle counter.
// PARAMETERS
//  MEM_TIMEOUT  15  max consecutive MEM_WAIT cycles without mem_ack before ERROR (range 1..255)
//  CNT_W        16  width of stall_count (saturating)
// PORTS
//  clk            in   1      rising-edge clock
//  rst            in   1      synchronous, active-high reset
//  load_use       in   1      load-use hazard request from ID-stage hazard detection
//  branch_taken   in   1      EX stage resolved a taken branch/jump this cycle
//  mem_req        in   1      MEM stage holds a load/store this cycle
//  mem_ack        in   1      data memory completes the MEM-stage access this cycle
//  halt_instr     in   1      halt instruction is in MEM stage
//  pc_write       out  1      PC register enable
//  ifid_write     out  1      IF/ID enable
//  idex_write     out  1      ID/EX enable
//  exmem_write    out  1      EX/MEM enable
//  ifid_flush     out  1      IF/ID load NOP
//  idex_flush     out  1      ID/EX control fields cleared (bubble)
//  memwb_bubble   out  1      MEM/WB loads bubble (no regfile write)
//  stall_cause    out  2      00 none, 01 load_use, 10 branch, 11 mem/halt/error
//  timeout_err    out  1      sticky; set on MEM_WAIT timeout
//  stall_count    out  CNT_W  cycles with pc_write==0, saturates at all-ones
// BEHAVIOUR
//  - Control outputs are combinational from state and inputs, effective in the same cycle.
//  - State, wait timer, timeout_err and stall_count are registered.
//  - Default ("normal") outputs: all *_write=1, flush/bubble=0, stall_cause=00.
//  - "Freeze" outputs: all *_write=0, flush=0, memwb_bubble=1, stall_cause=11.
//  - States: RUN, MEM_WAIT, HALTED, ERROR. Reset -> RUN; timer=0, timeout_err=0, stall_count=0.
//  - RUN, priority high to low:
//    1. halt_instr: freeze; next state HALTED.
//    2. mem_req && !mem_ack: freeze; next state MEM_WAIT; timer<=1.
//    3. branch_taken: ifid_flush=1, idex_flush=1, pc_write=1 (PC takes target), cause=10.
//    4. load_use: pc_write=0, ifid_write=0, idex_flush=1, cause=01.
//    5. Otherwise: normal.
//  - Branch beats load_use in the same cycle: the stalled instruction is on the wrong path.
//  - mem_req && mem_ack in RUN: zero-wait access, no stall; rules 3-5 apply.
//  - MEM_WAIT:
//    - !mem_ack: freeze; timer<=timer+1.
//      If timer==MEM_TIMEOUT: next state ERROR, timeout_err<=1.
//    - mem_ack: pipeline released this cycle. Rules 3-5 are evaluated exactly as in RUN.
//      Next state RUN; timer<=0.
//    - branch_taken/load_use are held upstream while frozen and act on release.
//  - HALTED and ERROR: freeze every cycle, all inputs ignored; exit only via rst.
//  - stall_count increments every cycle pc_write==0 (including HALTED/ERROR); holds at max.
//  - Reset mid-MEM_WAIT: return to RUN, normal outputs in the following cycle.
//    A pending mem_ack after reset is ignored unless mem_req is also high.
// TESTING
//  1. Reset, then all inputs 0 for 3 cycles
//     -> normal outputs; stall_count=0; stall_cause=00.
//  2. load_use=1 for 1 cycle in RUN
//     -> pc_write=0, ifid_write=0, idex_flush=1, cause=01; stall_count=1 next cycle.
//  3. load_use=1 and branch_taken=1 together
//     -> ifid_flush=1, idex_flush=1, pc_write=1, cause=10; stall_count unchanged.
//  4. mem_req=1, mem_ack low 3 cycles, then high 1 cycle
//     -> freeze for 3 cycles; normal outputs on the ack cycle; RUN after; stall_count=3.
//  5. mem_req=1, mem_ack never, MEM_TIMEOUT=15
//     -> ERROR after the 15th wait cycle; timeout_err=1 and freeze held until rst.
//  6. halt_instr=1, then rst=1 for 1 cycle
//     -> freeze each cycle until reset; normal outputs and timeout_err=0 the cycle after reset.

Source files
------------

// File: rtl/pipeline_stall_controller.sv
// Stall/flush scheduler for the 5-stage pipeline: arbitrates memory wait, branch flush
// and load-use bubbles, and tracks halt, memory timeout and total stall cycles.
module pipeline_stall_controller #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_use,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ack,
    input  logic             halt_instr,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_write,
    output logic             exmem_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             memwb_bubble,
    output logic [1:0]       stall_cause,
    output logic             timeout_err,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_MEM_WAIT,
        ST_HALTED,
        ST_ERROR
    } state_t;

    localparam logic [7:0]       TIMEOUT_VAL = 8'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

    localparam logic [1:0] CAUSE_NONE   = 2'b00;
    localparam logic [1:0] CAUSE_LOAD   = 2'b01;
    localparam logic [1:0] CAUSE_BRANCH = 2'b10;
    localparam logic [1:0] CAUSE_MEM    = 2'b11;

    state_t           state_reg, state_next;
    logic [7:0]       timer_reg, timer_next;
    logic             timeout_err_reg, timeout_err_next;
    logic [CNT_W-1:0] stall_count_reg, stall_count_next;

    logic freeze;
    logic apply_hazards;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_RUN;
            timer_reg       <= 8'd0;
            timeout_err_reg <= 1'b0;
            stall_count_reg <= '0;
        end else begin
            state_reg       <= state_next;
            timer_reg       <= timer_next;
            timeout_err_reg <= timeout_err_next;
            stall_count_reg <= stall_count_next;
        end
    end

    // Next state; also decides whether this cycle freezes or lets the hazard rules act.
    always_comb begin
        state_next       = state_reg;
        timer_next       = timer_reg;
        timeout_err_next = timeout_err_reg;
        freeze           = 1'b0;
        apply_hazards    = 1'b0;
        case (state_reg)
            ST_RUN: begin
                if (halt_instr) begin
                    freeze     = 1'b1;
                    state_next = ST_HALTED;
                end else if (mem_req && !mem_ack) begin
                    freeze     = 1'b1;
                    state_next = ST_MEM_WAIT;
                    timer_next = 8'd1;
                end else begin
                    apply_hazards = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                if (!mem_ack) begin
                    freeze     = 1'b1;
                    timer_next = timer_reg + 8'd1;
                    if (timer_reg == TIMEOUT_VAL) begin
                        state_next       = ST_ERROR;
                        timeout_err_next = 1'b1;
                    end
                end else begin
                    apply_hazards = 1'b1;
                    state_next    = ST_RUN;
                    timer_next    = 8'd0;
                end
            end
            default: begin
                freeze = 1'b1;
            end
        endcase
    end

    // A taken branch outranks load-use: the stalled instruction is on the wrong path.
    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        idex_write   = 1'b1;
        exmem_write  = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        memwb_bubble = 1'b0;
        stall_cause  = CAUSE_NONE;
        if (freeze) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_write  = 1'b0;
            memwb_bubble = 1'b1;
            stall_cause  = CAUSE_MEM;
        end else if (apply_hazards) begin
            if (branch_taken) begin
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                stall_cause = CAUSE_BRANCH;
            end else if (load_use) begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_flush  = 1'b1;
                stall_cause = CAUSE_LOAD;
            end
        end
    end

    always_comb begin
        stall_count_next = stall_count_reg;
        if (!pc_write && (stall_count_reg != CNT_MAX)) begin
            stall_count_next = stall_count_reg + 1'b1;
        end
    end

    assign timeout_err = timeout_err_reg;
    assign stall_count = stall_count_reg;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller: one task per scenario with inline checks.
module tb_pipeline_stall_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_use, branch_taken, mem_req, mem_ack, halt_instr;
    logic        pc_write, ifid_write, idex_write, exmem_write;
    logic        ifid_flush, idex_flush, memwb_bubble;
    logic [1:0]  stall_cause;
    logic        timeout_err;
    logic [15:0] stall_count;
    logic [8:0]  ctrl;

    int errors = 0;
    int checks = 0;

    // {pc_w, ifid_w, idex_w, exmem_w, ifid_flush, idex_flush, memwb_bubble, cause}
    localparam logic [8:0] C_NORMAL = 9'b1111_000_00;
    localparam logic [8:0] C_FREEZE = 9'b0000_001_11;
    localparam logic [8:0] C_LOAD   = 9'b0011_010_01;
    localparam logic [8:0] C_BRANCH = 9'b1111_110_10;

    always #5 clk = ~clk;

    assign ctrl = {pc_write, ifid_write, idex_write, exmem_write,
                   ifid_flush, idex_flush, memwb_bubble, stall_cause};

    pipeline_stall_controller #(.MEM_TIMEOUT(15), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .load_use(load_use), .branch_taken(branch_taken),
        .mem_req(mem_req), .mem_ack(mem_ack), .halt_instr(halt_instr),
        .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write),
        .exmem_write(exmem_write), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .memwb_bubble(memwb_bubble), .stall_cause(stall_cause),
        .timeout_err(timeout_err), .stall_count(stall_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        load_use = 0; branch_taken = 0; mem_req = 0; mem_ack = 0; halt_instr = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1;
        tick(); tick();
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (ctrl !== C_NORMAL || stall_count !== 16'd0) begin
                errors++;
                $display("FAIL reset_idle cyc%0d: ctrl=%b cnt=%0d expected ctrl=%b cnt=0", i, ctrl, stall_count, C_NORMAL);
            end
            tick();
        end
        $display("test_reset done: ctrl=%b cnt=%0d", ctrl, stall_count);
    endtask

    task automatic test_load_use();
        load_use = 1;
        #1;
        checks++;
        if (ctrl !== C_LOAD || stall_count !== 16'd0) begin
            errors++;
            $display("FAIL load_use: ctrl=%b cnt=%0d expected ctrl=%b cnt=0", ctrl, stall_count, C_LOAD);
        end
        tick();
        load_use = 0;
        #1;
        checks++;
        if (ctrl !== C_NORMAL || stall_count !== 16'd1) begin
            errors++;
            $display("FAIL load_use_after: ctrl=%b cnt=%0d expected ctrl=%b cnt=1", ctrl, stall_count, C_NORMAL);
        end
        $display("test_load_use: cnt=%0d", stall_count);
    endtask

    task automatic test_branch_beats_load();
        load_use = 1; branch_taken = 1;
        #1;
        checks++;
        if (ctrl !== C_BRANCH) begin
            errors++;
            $display("FAIL branch_priority: ctrl=%b expected %b", ctrl, C_BRANCH);
        end
        tick();
        clear_inputs();
        #1;
        checks++;
        if (stall_count !== 16'd1) begin
            errors++;
            $display("FAIL branch_count: cnt=%0d expected 1", stall_count);
        end
        $display("test_branch_beats_load: cnt=%0d", stall_count);
    endtask

    task automatic test_mem_wait();
        mem_req = 1; mem_ack = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (ctrl !== C_FREEZE) begin
                errors++;
                $display("FAIL mem_wait_freeze cyc%0d: ctrl=%b expected %b", i, ctrl, C_FREEZE);
            end
            tick();
        end
        mem_ack = 1;
        #1;
        checks++;
        if (ctrl !== C_NORMAL) begin
            errors++;
            $display("FAIL mem_ack_release: ctrl=%b expected %b", ctrl, C_NORMAL);
        end
        tick();
        clear_inputs();
        #1;
        checks++;
        if (ctrl !== C_NORMAL || stall_count !== 16'd4 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL mem_after: ctrl=%b cnt=%0d terr=%b expected ctrl=%b cnt=4 terr=0", ctrl, stall_count, timeout_err, C_NORMAL);
        end
        $display("test_mem_wait: cnt=%0d", stall_count);
    endtask

    task automatic test_release_branch();
        mem_req = 1; mem_ack = 0;
        tick();
        mem_ack = 1; branch_taken = 1;
        #1;
        checks++;
        if (ctrl !== C_BRANCH) begin
            errors++;
            $display("FAIL release_branch: ctrl=%b expected %b", ctrl, C_BRANCH);
        end
        tick();
        // Zero-wait access in RUN does not stall; load-use still applies.
        branch_taken = 0; mem_req = 1; mem_ack = 1; load_use = 1;
        #1;
        checks++;
        if (ctrl !== C_LOAD || stall_count !== 16'd5) begin
            errors++;
            $display("FAIL zero_wait_load: ctrl=%b cnt=%0d expected ctrl=%b cnt=5", ctrl, stall_count, C_LOAD);
        end
        tick();
        clear_inputs();
        #1;
        checks++;
        if (ctrl !== C_NORMAL || stall_count !== 16'd6) begin
            errors++;
            $display("FAIL zero_wait_after: ctrl=%b cnt=%0d expected ctrl=%b cnt=6", ctrl, stall_count, C_NORMAL);
        end
        $display("test_release_branch: cnt=%0d", stall_count);
    endtask

    task automatic test_timeout();
        mem_req = 1; mem_ack = 0;
        for (int i = 0; i < 16; i++) begin
            #1;
            checks++;
            if (ctrl !== C_FREEZE || timeout_err !== 1'b0) begin
                errors++;
                $display("FAIL timeout_wait cyc%0d: ctrl=%b terr=%b expected ctrl=%b terr=0", i, ctrl, timeout_err, C_FREEZE);
            end
            tick();
        end
        #1;
        checks++;
        if (timeout_err !== 1'b1 || ctrl !== C_FREEZE || stall_count !== 16'd22) begin
            errors++;
            $display("FAIL timeout_entry: terr=%b ctrl=%b cnt=%0d expected terr=1 ctrl=%b cnt=22", timeout_err, ctrl, stall_count, C_FREEZE);
        end
        // ERROR ignores every input, including a late ack.
        mem_ack = 1; branch_taken = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            checks++;
            if (ctrl !== C_FREEZE || timeout_err !== 1'b1) begin
                errors++;
                $display("FAIL error_hold cyc%0d: ctrl=%b terr=%b expected ctrl=%b terr=1", i, ctrl, timeout_err, C_FREEZE);
            end
        end
        clear_inputs();
        rst = 1;
        tick();
        rst = 0;
        #1;
        checks++;
        if (ctrl !== C_NORMAL || timeout_err !== 1'b0 || stall_count !== 16'd0) begin
            errors++;
            $display("FAIL error_reset: ctrl=%b terr=%b cnt=%0d expected ctrl=%b terr=0 cnt=0", ctrl, timeout_err, stall_count, C_NORMAL);
        end
        $display("test_timeout: terr=%b cnt=%0d", timeout_err, stall_count);
    endtask

    task automatic test_halt();
        halt_instr = 1;
        #1;
        checks++;
        if (ctrl !== C_FREEZE) begin
            errors++;
            $display("FAIL halt_entry: ctrl=%b expected %b", ctrl, C_FREEZE);
        end
        tick();
        halt_instr = 0; load_use = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (ctrl !== C_FREEZE || stall_count !== 16'(i + 1)) begin
                errors++;
                $display("FAIL halt_hold cyc%0d: ctrl=%b cnt=%0d expected ctrl=%b cnt=%0d", i, ctrl, stall_count, C_FREEZE, i + 1);
            end
            tick();
        end
        clear_inputs();
        rst = 1;
        tick();
        rst = 0;
        #1;
        checks++;
        if (ctrl !== C_NORMAL || timeout_err !== 1'b0 || stall_count !== 16'd0) begin
            errors++;
            $display("FAIL halt_reset: ctrl=%b terr=%b cnt=%0d expected ctrl=%b terr=0 cnt=0", ctrl, timeout_err, stall_count, C_NORMAL);
        end
        $display("test_halt: ctrl=%b", ctrl);
    endtask

    task automatic test_reset_mid_wait();
        mem_req = 1; mem_ack = 0;
        tick(); tick();
        rst = 1; mem_req = 0; mem_ack = 1;
        tick();
        rst = 0;
        #1;
        checks++;
        if (ctrl !== C_NORMAL) begin
            errors++;
            $display("FAIL reset_mid_wait: ctrl=%b expected %b", ctrl, C_NORMAL);
        end
        tick();
        checks++;
        if (ctrl !== C_NORMAL || stall_count !== 16'd0) begin
            errors++;
            $display("FAIL stray_ack: ctrl=%b cnt=%0d expected ctrl=%b cnt=0", ctrl, stall_count, C_NORMAL);
        end
        clear_inputs();
        $display("test_reset_mid_wait: ctrl=%b cnt=%0d", ctrl, stall_count);
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch_beats_load();
        test_mem_wait();
        test_release_branch();
        test_timeout();
        test_halt();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
